sync_timing_gen: RTL

Video timing generator for the Sprint 1 video path, sitting directly upstream of the vertical sync PROM. It runs the horizontal and vertical pixel counters, drives the PROM address from the line count, and registers the PROM's 4-bit output into the vertical blank and sync signals. It also decodes horizontal sync and blank from the counters and emits line/frame strobes for the playfield and motion-object logic.

---
 rtl/sync_timing_pkg.sv | 31 +++
 rtl/sync_timing_gen_mod_counter.sv | 52 +++++
 rtl/sync_timing_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sync_timing_pkg.sv
// ============================================================================
// Module      : sync_timing_pkg
// Description : Shared timing constants, PROM bit map and address helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sync_timing_pkg;

  localparam int CNT_W = 9;

  localparam int DEFAULT_H_TOTAL      = 384;
  localparam int DEFAULT_H_ACTIVE     = 256;
  localparam int DEFAULT_H_SYNC_START = 288;
  localparam int DEFAULT_H_SYNC_END   = 320;
  localparam int DEFAULT_V_TOTAL      = 262;
  localparam int DEFAULT_PROM_SAMPLE  = 2;

  localparam int PROM_VBLANK_BIT = 3;
  localparam int PROM_AUX_HI_BIT = 2;
  localparam int PROM_AUX_LO_BIT = 1;
  localparam int PROM_VSYNC_BIT  = 0;

  // Lines past the 8-bit PROM range all share the last PROM entry.
  function automatic logic [7:0] prom_addr_of(input logic [CNT_W-1:0] line);
    return (line > CNT_W'(8'hFF)) ? 8'hFF : line[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_timing_gen_mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Enabled modulo-N counter exposing its next value and a wrap
//               pulse that is high in the cycle the wrap is taken.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mod_counter #(
  parameter int MODULUS = 384,
  parameter int WIDTH   = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

  always_comb begin
    wrap_d  = 1'b0;
    count_d = count_q;
    if (en_i) begin
      if (count_q == WIDTH'(MODULUS - 1)) begin
        wrap_d  = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;
  assign wrap_o  = wrap_d;

endmodule

`default_nettype wire

// File: rtl/sync_timing_gen.sv
// ============================================================================
// Module      : sync_timing_gen
// Description : Video timing generator driving the vertical sync PROM and
//               decoding horizontal sync/blank plus line/frame strobes.
//               Optional macro SYNC_TIMING_FRAME_CNT_EN adds a frame counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_timing_gen
  import sync_timing_pkg::*;
#(
  parameter int H_TOTAL      = DEFAULT_H_TOTAL,
  parameter int H_ACTIVE     = DEFAULT_H_ACTIVE,
  parameter int H_SYNC_START = DEFAULT_H_SYNC_START,
  parameter int H_SYNC_END   = DEFAULT_H_SYNC_END,
  parameter int V_TOTAL      = DEFAULT_V_TOTAL,
  parameter int PROM_SAMPLE  = DEFAULT_PROM_SAMPLE
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pix_ce,
  output logic [7:0]       prom_addr,
  input  logic [3:0]       prom_q,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             hblank,
  output logic             vsync,
  output logic             vblank,
  output logic [1:0]       vaux,
  output logic             line_start,
`ifdef SYNC_TIMING_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             frame_start
);

  logic [CNT_W-1:0] h_next, v_next;
  logic             h_wrap, v_wrap;

  logic [7:0] prom_addr_q, prom_addr_d;
  logic       hsync_q, hsync_d;
  logic       hblank_q, hblank_d;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;
  logic [1:0] vaux_q, vaux_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  mod_counter #(.MODULUS(H_TOTAL), .WIDTH(CNT_W)) u_hcnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (pix_ce),
    .count_o (hcount),
    .next_o  (h_next),
    .wrap_o  (h_wrap)
  );

  // h_wrap already carries pix_ce, so the line counter only moves on a live pixel.
  mod_counter #(.MODULUS(V_TOTAL), .WIDTH(CNT_W)) u_vcnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (h_wrap),
    .count_o (vcount),
    .next_o  (v_next),
    .wrap_o  (v_wrap)
  );

  always_comb begin
    prom_addr_d   = prom_addr_q;
    hsync_d       = hsync_q;
    hblank_d      = hblank_q;
    vsync_d       = vsync_q;
    vblank_d      = vblank_q;
    vaux_d        = vaux_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      hblank_d = (h_next >= CNT_W'(H_ACTIVE));
      hsync_d  = (h_next >= CNT_W'(H_SYNC_START)) && (h_next < CNT_W'(H_SYNC_END));
      // PROM data for this line is valid once the address has had a clock to settle.
      if (h_next == CNT_W'(PROM_SAMPLE)) begin
        vblank_d = prom_q[PROM_VBLANK_BIT];
        vsync_d  = prom_q[PROM_VSYNC_BIT];
        vaux_d   = prom_q[PROM_AUX_HI_BIT:PROM_AUX_LO_BIT];
      end
      if (h_wrap) begin
        prom_addr_d   = prom_addr_of(v_next);
        line_start_d  = 1'b1;
        frame_start_d = v_wrap;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prom_addr_q   <= '0;
      hsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      vaux_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      prom_addr_q   <= prom_addr_d;
      hsync_q       <= hsync_d;
      hblank_q      <= hblank_d;
      vsync_q       <= vsync_d;
      vblank_q      <= vblank_d;
      vaux_q        <= vaux_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef SYNC_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (h_wrap && v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign prom_addr   = prom_addr_q;
  assign hsync       = hsync_q;
  assign hblank      = hblank_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign vaux        = vaux_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire
